// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM Avalon-MM arbiter.
package sdram_arb_pkg;

  typedef enum logic [0:0] {IDLE, BUSY} arb_state_t;

  localparam int unsigned BE_W = 2;

  // Width of a master index; never zero so single-bit IDs stay legal.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_arb_id_fifo.sv
// Small FIFO of master IDs for reads accepted by the slave but not yet returned.
module sdram_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM slave between several masters,
// with pipelined reads routed back through a queue of issuing master IDs.
module sdram_avalon_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_W      = 25,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             s_address,
  output logic                          s_read,
  output logic                          s_write,
  output logic [DATA_W-1:0]             s_writedata,
  output logic [BE_W-1:0]               s_byteenable,
  input  logic                          s_waitrequest,
  input  logic [DATA_W-1:0]             s_readdata,
  input  logic                          s_readdatavalid,
  output logic                          err_underflow
);

  localparam int unsigned ID_W  = id_width(NUM_MASTERS);
  localparam int unsigned CNT_W = $clog2(MAX_PENDING) + 1;

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             err_underflow_q;

  logic [NUM_MASTERS-1:0] request;
  logic [ID_W-1:0]        pick_id;
  logic                   g_read, g_write, is_read, read_blocked, accept;
  logic                   push, pop;
  logic [ID_W-1:0]        head_id;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count, post_pop_count;

  assign request = m_read | m_write;
  assign g_read  = m_read[grant_q];
  assign g_write = m_write[grant_q];
  // Write wins when both strobes are high.
  assign is_read = g_read & ~g_write;

  assign pop            = s_readdatavalid & ~fifo_empty;
  assign post_pop_count = fifo_count - CNT_W'(pop);
  assign read_blocked   = (state_q == BUSY) & is_read & (post_pop_count == CNT_W'(MAX_PENDING));
  assign accept         = (state_q == BUSY) & (s_read | s_write) & ~s_waitrequest;
  assign push           = accept & s_read & (~fifo_full | pop);

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    logic        found;
    int unsigned idx;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_MASTERS;
      if (!found && request[idx]) begin
        found   = 1'b1;
        pick_id = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= '0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      if (s_readdatavalid && fifo_empty) begin
        err_underflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|request) begin
          state_d = BUSY;
          grant_d = pick_id;
        end
      end
      BUSY: begin
        if (accept) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        end else if (!(g_read || g_write)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_address       = '0;
    s_read          = 1'b0;
    s_write         = 1'b0;
    s_writedata     = '0;
    s_byteenable    = '0;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    if (state_q == BUSY) begin
      s_address              = m_address[grant_q*ADDR_W +: ADDR_W];
      s_writedata            = m_writedata[grant_q*DATA_W +: DATA_W];
      s_byteenable           = m_byteenable[grant_q*BE_W +: BE_W];
      s_read                 = is_read & ~read_blocked;
      s_write                = g_write;
      m_waitrequest[grant_q] = s_waitrequest | read_blocked;
    end
    if (pop) begin
      m_readdatavalid[head_id] = 1'b1;
    end
  end

  assign m_readdata    = s_readdata;
  assign err_underflow = err_underflow_q;

  sdram_arb_id_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push),
    .pop   (pop),
    .din   (grant_q),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_sdram_avalon_arbiter.sv
// Bench for sdram_avalon_arbiter: cycle table, hand-built corner sequences, then random traffic
// checked against a transaction-level model (round-robin rule plus a queue of read issuers).
module tb_sdram_avalon_arbiter;

  localparam int N  = 2;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int MP = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] m_address;
  logic [N-1:0]    m_read, m_write;
  logic [N*DW-1:0] m_writedata;
  logic [N*2-1:0]  m_byteenable;
  logic [N-1:0]    m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [N-1:0]    m_readdatavalid;
  logic [AW-1:0]   s_address;
  logic            s_read, s_write;
  logic [DW-1:0]   s_writedata;
  logic [1:0]      s_byteenable;
  logic            s_waitrequest;
  logic [DW-1:0]   s_readdata;
  logic            s_readdatavalid;
  logic            err_underflow;

  always #5 clk = ~clk;

  sdram_avalon_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .MAX_PENDING (MP)
  ) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .err_underflow   (err_underflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_req(input int from, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        sw;
    logic        srdv;
    logic [15:0] sdata;
    logic        exp_sr;
    logic        exp_sw;
    logic [24:0] exp_addr;
    logic [15:0] exp_wd;
    logic [1:0]  exp_mw;
    logic [1:0]  exp_rdv;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  // Random-phase model state
  int            q_id[$];
  bit            act[N];
  bit            mrd[N], mwr[N];
  logic [AW-1:0] maddr[N];
  logic [DW-1:0] mwd[N];
  logic [1:0]    mbe[N];
  int            wait_cnt[N];
  int            last_g, exp_g, hs, acc;
  bit            arb_open, bail, bus_acc;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rd, wr, sw, srdv, sdata | s_read, s_write, s_address, s_writedata, m_wait, m_rdv, err
    vecs[0]  = '{2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[1]  = '{2'b00, 2'b11, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[2]  = '{2'b00, 2'b11, 0, 0, 16'h0000, 0, 1, 25'h100, 16'h1111, 2'b10, 2'b00, 0};
    vecs[3]  = '{2'b00, 2'b11, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[4]  = '{2'b00, 2'b11, 0, 0, 16'h0000, 0, 1, 25'h200, 16'h2222, 2'b01, 2'b00, 0};
    vecs[5]  = '{2'b01, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[6]  = '{2'b01, 2'b00, 1, 0, 16'h0000, 1, 0, 25'h100, 16'h1111, 2'b11, 2'b00, 0};
    vecs[7]  = '{2'b01, 2'b00, 0, 0, 16'h0000, 1, 0, 25'h100, 16'h1111, 2'b10, 2'b00, 0};
    vecs[8]  = '{2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[9]  = '{2'b00, 2'b00, 0, 1, 16'hBEEF, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b01, 0};
    vecs[10] = '{2'b00, 2'b00, 0, 1, 16'hDEAD, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 0};
    vecs[11] = '{2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 1};
    vecs[12] = '{2'b10, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 1};
    vecs[13] = '{2'b00, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h200, 16'h2222, 2'b01, 2'b00, 1};
    vecs[14] = '{2'b11, 2'b00, 0, 0, 16'h0000, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b00, 1};
    vecs[15] = '{2'b11, 2'b00, 0, 0, 16'h0000, 1, 0, 25'h200, 16'h2222, 2'b01, 2'b00, 1};
    vecs[16] = '{2'b00, 2'b00, 0, 1, 16'h1234, 0, 0, 25'h000, 16'h0000, 2'b11, 2'b10, 1};

    rst_n           = 1'b0;
    m_address       = {25'h200, 25'h100};
    m_read          = '0;
    m_write         = '0;
    m_writedata     = {16'h2222, 16'h1111};
    m_byteenable    = {2'b10, 2'b01};
    s_waitrequest   = 1'b0;
    s_readdata      = '0;
    s_readdatavalid = 1'b0;
    #1;
    check("reset_s_read", s_read, 0);
    check("reset_s_write", s_write, 0);
    check("reset_s_address", s_address, 0);
    check("reset_m_waitrequest", m_waitrequest, 2'b11);
    check("reset_err", err_underflow, 0);
    tick();
    rst_n = 1'b1;

    // Cycle table: alternating writes, stalled read, return, underflow, master drop
    for (int r = 0; r < 17; r++) begin
      m_read          = vecs[r].rd;
      m_write         = vecs[r].wr;
      s_waitrequest   = vecs[r].sw;
      s_readdatavalid = vecs[r].srdv;
      s_readdata      = vecs[r].sdata;
      @(negedge clk);
      check($sformatf("vec%0d_s_read", r), s_read, vecs[r].exp_sr);
      check($sformatf("vec%0d_s_write", r), s_write, vecs[r].exp_sw);
      check($sformatf("vec%0d_s_address", r), s_address, vecs[r].exp_addr);
      check($sformatf("vec%0d_s_writedata", r), s_writedata, vecs[r].exp_wd);
      check($sformatf("vec%0d_m_waitrequest", r), m_waitrequest, vecs[r].exp_mw);
      check($sformatf("vec%0d_m_readdatavalid", r), m_readdatavalid, vecs[r].exp_rdv);
      check($sformatf("vec%0d_m_readdata", r), m_readdata, vecs[r].sdata);
      check($sformatf("vec%0d_err", r), err_underflow, vecs[r].exp_err);
      tick();
    end
    s_readdatavalid = 1'b0;

    // Queue full: four reads accepted, fifth stalls until a return frees a slot
    m_read = 2'b01;
    acc    = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      @(negedge clk);
      if (!m_waitrequest[0]) acc++;
      tick();
    end
    check("full_four_accepted", acc, 4);
    tick();
    tick();
    @(negedge clk);
    check("full_s_read_held", s_read, 0);
    check("full_waitrequest", m_waitrequest, 2'b11);
    tick();
    s_readdatavalid = 1'b1;
    s_readdata      = 16'hA5A5;
    @(negedge clk);
    check("full_pop_rdv", m_readdatavalid, 2'b01);
    check("full_pop_rdata", m_readdata, 16'hA5A5);
    check("full_push_s_read", s_read, 1);
    check("full_push_waitrequest", m_waitrequest, 2'b10);
    tick();
    m_read = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("drain_rdv", m_readdatavalid, 2'b01);
      tick();
    end
    s_readdatavalid = 1'b0;

    // Reset with two reads in flight and a stalled write
    m_write       = 2'b10;
    s_waitrequest = 1'b1;
    tick();
    @(negedge clk);
    check("stall_s_write", s_write, 1);
    check("stall_waitrequest", m_waitrequest, 2'b11);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_s_write", s_write, 0);
    check("arst_s_read", s_read, 0);
    check("arst_s_address", s_address, 0);
    check("arst_s_writedata", s_writedata, 0);
    check("arst_s_byteenable", s_byteenable, 0);
    check("arst_waitrequest", m_waitrequest, 2'b11);
    check("arst_rdv", m_readdatavalid, 2'b00);
    check("arst_err", err_underflow, 0);
    tick();
    rst_n           = 1'b1;
    m_write         = 2'b00;
    s_waitrequest   = 1'b0;
    s_readdatavalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_reset_return_rdv", m_readdatavalid, 2'b00);
      tick();
    end
    s_readdatavalid = 1'b0;
    @(negedge clk);
    check("post_reset_underflow", err_underflow, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("underflow_cleared", err_underflow, 0);
    tick();
    rst_n = 1'b1;

    // Random traffic against the transaction-level model
    last_g   = N - 1;
    arb_open = 1'b1;
    exp_g    = -1;
    bail     = 1'b0;
    for (int i = 0; i < N; i++) begin
      act[i]      = 1'b0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 3000 && !bail; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          int op;
          op       = int'($urandom_range(0, 3));
          act[i]   = 1'b1;
          mrd[i]   = (op != 2);
          mwr[i]   = (op >= 2);
          maddr[i] = AW'($urandom);
          mwd[i]   = DW'($urandom);
          mbe[i]   = 2'($urandom);
        end
        m_read[i]                = act[i] & mrd[i];
        m_write[i]               = act[i] & mwr[i];
        m_address[i*AW +: AW]    = maddr[i];
        m_writedata[i*DW +: DW]  = mwd[i];
        m_byteenable[i*2 +: 2]   = mbe[i];
      end
      s_waitrequest   = ($urandom_range(0, 3) == 0);
      s_readdatavalid = (q_id.size() > 0) && ($urandom_range(0, 2) == 0);
      s_readdata      = DW'($urandom);
      @(negedge clk);

      if (arb_open && (m_read | m_write) != '0) begin
        exp_g    = first_req((last_g + 1) % N, m_read | m_write);
        arb_open = 1'b0;
      end

      if (s_readdatavalid) begin
        check("rnd_rdv_route", m_readdatavalid, N'(1) << q_id[0]);
        check("rnd_rdata", m_readdata, s_readdata);
        void'(q_id.pop_front());
      end else begin
        check("rnd_rdv_idle", m_readdatavalid, 0);
      end

      hs = -1;
      for (int i = 0; i < N; i++) begin
        if (!m_waitrequest[i]) begin
          if (!act[i] || hs != -1) begin
            check("rnd_spurious_ack", i, hs);
          end
          hs = i;
        end
      end
      bus_acc = (s_read | s_write) & ~s_waitrequest;
      check("rnd_ack_vs_bus", (hs >= 0), bus_acc);
      if (hs >= 0) begin
        check("rnd_rr_grant", hs, exp_g);
        check("rnd_s_read", s_read, mrd[hs] & ~mwr[hs]);
        check("rnd_s_write", s_write, mwr[hs]);
        check("rnd_s_address", s_address, maddr[hs]);
        if (mwr[hs]) begin
          check("rnd_s_writedata", s_writedata, mwd[hs]);
          check("rnd_s_byteenable", s_byteenable, mbe[hs]);
        end else begin
          q_id.push_back(hs);
          check("rnd_pending_bound", (q_id.size() <= MP), 1);
        end
        act[hs]      = 1'b0;
        wait_cnt[hs] = 0;
        last_g       = hs;
        exp_g        = -1;
        arb_open     = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > 60) begin
            check("rnd_wait_timeout", wait_cnt[i], 0);
            bail = 1'b1;
          end
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
